// File: rtl/aes_inv_cipher_top.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_top (+ aes_inv_cipher_sbox)
// Brief    : AES-128 inverse cipher, one round per clock, stored round keys
// Revision : 1.0 - initial release
// ============================================================================

module aes_inv_cipher_sbox #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 as the product of a^2, a^4, ... a^128; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] w_b;

    always_comb begin
        w_b = 8'h00;
        o_y = 8'h00;
        if (INVERSE) begin
            w_b = {i_a[6:0], i_a[7]} ^ {i_a[4:0], i_a[7:5]} ^ {i_a[1:0], i_a[7:2]} ^ 8'h05;
            o_y = gf_inv(w_b);
        end else begin
            w_b = gf_inv(i_a);
            o_y = w_b ^ {w_b[6:0], w_b[7]} ^ {w_b[5:0], w_b[7:6]}
                      ^ {w_b[4:0], w_b[7:5]} ^ {w_b[3:0], w_b[7:4]} ^ 8'h63;
        end
    end
endmodule

module aes_inv_cipher_top #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         kdone,
    output logic         done,
    output logic         busy,
    output logic [127:0] text_out
);
    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_inv_cipher_top: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] c_last = 4'(NR);

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_KEXP  = 2'd1,
        S_READY = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [127:0]   r_kw;
    logic [127:0]   r_st;
    logic           r_rk_valid;
    logic [127:0]   r_rk [0:NR];
    logic           w_dstart;
    logic [127:0]   w_rk;
    logic [127:0]   w_shift;
    logic [127:0]   w_sub;
    logic [127:0]   w_ark;
    logic [127:0]   w_mix;
    logic [31:0]    w_rot;
    logic [31:0]    w_subw;
    logic [127:0]   w_kw_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Round counter doubles as buffer index: BUSY step n uses rk[10-n]
    assign w_rk = r_rk[c_last - r_cnt];

    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                localparam int c_dst = c * 4 + r;
                localparam int c_src = ((c - r + 4) % 4) * 4 + r;
                assign w_shift[127 - 8*c_dst -: 8] = r_st[127 - 8*c_src -: 8];
                aes_inv_cipher_sbox #(.INVERSE(1'b1)) u_isbox (
                    .i_a (w_shift[127 - 8*c_dst -: 8]),
                    .o_y (w_sub[127 - 8*c_dst -: 8])
                );
            end
            assign w_mix[127 - 32*c -: 32] = inv_mix_col(w_ark[127 - 32*c -: 32]);
        end
        for (genvar i = 0; i < 4; i++) begin : g_ksbox
            aes_inv_cipher_sbox #(.INVERSE(1'b0)) u_sbox (
                .i_a (w_rot[8*i +: 8]),
                .o_y (w_subw[8*i +: 8])
            );
        end
    endgenerate

    assign w_ark = w_sub ^ w_rk;
    assign w_rot = {r_kw[23:0], r_kw[31:24]};

    always_comb begin
        w_kw_nxt[127:96] = r_kw[127:96] ^ w_subw ^ {rcon(r_cnt), 24'h000000};
        w_kw_nxt[95:64]  = r_kw[95:64] ^ w_kw_nxt[127:96];
        w_kw_nxt[63:32]  = r_kw[63:32] ^ w_kw_nxt[95:64];
        w_kw_nxt[31:0]   = r_kw[31:0]  ^ w_kw_nxt[63:32];
    end

    always_comb begin
        w_dstart    = (r_state == S_READY) && r_rk_valid && ld && !kld;
        w_state_nxt = r_state;
        case (r_state)
            S_NOKEY: if (kld) w_state_nxt = S_KEXP;
            S_KEXP:  if (!kld && r_cnt == c_last) w_state_nxt = S_READY;
            S_READY: begin
                if (kld)           w_state_nxt = S_KEXP;
                else if (w_dstart) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (kld)                  w_state_nxt = S_KEXP;
                else if (r_cnt == c_last) w_state_nxt = S_READY;
            end
            default: w_state_nxt = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_NOKEY;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 4'd0;
            r_kw       <= '0;
            r_st       <= '0;
            r_rk_valid <= 1'b0;
            kdone      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            text_out   <= '0;
        end else begin
            kdone <= 1'b0;
            done  <= 1'b0;
            if (kld) begin
                r_kw       <= key;
                r_cnt      <= 4'd0;
                r_rk_valid <= 1'b0;
                busy       <= 1'b0;
            end else if (r_state == S_KEXP) begin
                r_kw  <= w_kw_nxt;
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == c_last) begin
                    kdone      <= 1'b1;
                    r_rk_valid <= 1'b1;
                end
            end else if (w_dstart) begin
                r_st  <= text_in;
                r_cnt <= 4'd0;
                busy  <= 1'b1;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd0) begin
                    r_st <= r_st ^ w_rk;
                end else if (r_cnt == c_last) begin
                    text_out <= w_ark;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end else begin
                    r_st <= w_mix;
                end
            end
        end
    end

    // Buffer contents are don't-care after reset; the valid flag guards use
    always_ff @(posedge clk) begin
        if (r_state == S_KEXP && !kld) r_rk[r_cnt] <= r_kw;
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_top
// Brief    : directed bench for aes_inv_cipher_top with a byte-matrix model
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_top;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         kld = 1'b0;
    logic [127:0] key = '0;
    logic         ld = 1'b0;
    logic [127:0] text_in = '0;
    logic         kdone, done, busy;
    logic [127:0] text_out;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] c_key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ct_a  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_pt_a  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_key_b = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_ct_b  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_pt_b  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_inv_cipher_top #(.NR(10)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .ld       (ld),
        .text_in  (text_in),
        .kdone    (kdone),
        .done     (done),
        .busy     (busy),
        .text_out (text_out)
    );

    task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (plain GF arithmetic, byte matrix) ----
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] aff;
        aff = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff[i];
            sb[x]  = s;
            isb[s] = x[7:0];
        end
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ w[40 + c][31 - 8*r -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = isb[s[r][(c - r + 4) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = t[r][c] ^ w[4*rd + c][31 - 8*r -: 8];
            if (rd != 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        t[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            t[r][c] = t[r][c] ^ gmul(m[(j - r + 4) % 4], s[j][c]);
                    end
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // Cycle-level expectation: countdowns for expansion and decryption
    int           m_kcnt, m_bcnt;
    logic         m_ready;
    logic [127:0] m_key, m_newkey, m_ct;
    logic         exp_kdone, exp_done, exp_busy;
    logic [127:0] exp_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_kcnt    <= 0;
            m_bcnt    <= 0;
            m_ready   <= 1'b0;
            m_key     <= '0;
            m_newkey  <= '0;
            m_ct      <= '0;
            exp_kdone <= 1'b0;
            exp_done  <= 1'b0;
            exp_busy  <= 1'b0;
            exp_out   <= '0;
        end else begin
            exp_kdone <= 1'b0;
            exp_done  <= 1'b0;
            if (kld) begin
                m_kcnt   <= 11;
                m_newkey <= key;
                m_bcnt   <= 0;
                m_ready  <= 1'b0;
                exp_busy <= 1'b0;
            end else if (m_kcnt > 0) begin
                m_kcnt <= m_kcnt - 1;
                if (m_kcnt == 1) begin
                    exp_kdone <= 1'b1;
                    m_key     <= m_newkey;
                    m_ready   <= 1'b1;
                end
            end else if (m_bcnt > 0) begin
                m_bcnt <= m_bcnt - 1;
                if (m_bcnt == 1) begin
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                    exp_out  <= model_decrypt(m_ct, m_key);
                end
            end else if (m_ready && ld) begin
                m_bcnt   <= 11;
                m_ct     <= text_in;
                exp_busy <= 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_b("kdone", kdone, exp_kdone);
            check_b("done", done, exp_done);
            check_b("busy", busy, exp_busy);
            check_v("text_out", text_out, exp_out);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ---------------
    task automatic pulse_kld(input logic [127:0] k);
        kld = 1'b1;
        key = k;
        @(negedge clk);
        kld = 1'b0;
    endtask

    task automatic start_ld(input logic [127:0] ct);
        ld      = 1'b1;
        text_in = ct;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_evt(input bit want_done, input int max, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        forever begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
            if (want_done ? done : kdone) break;
            if (lat >= max) begin
                checks++;
                errors++;
                $display("FAIL wait_%s: no pulse within %0d cycles", want_done ? "done" : "kdone", max);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, n;
        build_tables();
        check_i("sbox_00", int'(sb[8'h00]), 'h63);
        check_i("sbox_53", int'(sb[8'h53]), 'hed);
        check_i("isbox_00", int'(isb[8'h00]), 'h52);

        repeat (3) @(negedge clk);
        check_b("rst_kdone", kdone, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_v("rst_text", text_out, '0);
        rst = 1'b1;

        // ld without a key
        start_ld(c_ct_a);
        bc = 0;
        repeat (15) begin
            if (busy || done) bc++;
            @(negedge clk);
        end
        check_i("nokey_activity", bc, 0);
        check_v("nokey_text", text_out, '0);

        // key expansion with an ld arriving mid-expansion
        pulse_kld(c_key_a);
        lat = 0;
        bc  = 0;
        while (!kdone && lat < 20) begin
            if (busy) bc++;
            ld      = (lat == 3);
            text_in = c_ct_a;
            @(negedge clk);
            lat++;
        end
        ld = 1'b0;
        check_i("kdone_lat", lat, 11);
        check_i("kexp_busy", bc, 0);
        check_v("kexp_text", text_out, '0);

        start_ld(c_ct_a);
        wait_evt(1'b1, 30, lat, bc);
        check_i("done_lat_a", lat, 11);
        check_i("busy_cycles_a", bc, 11);
        check_v("pt_a", text_out, c_pt_a);

        // second key, buffer reuse
        pulse_kld(c_key_b);
        wait_evt(1'b0, 30, lat, bc);
        check_i("kdone_lat_b", lat, 11);
        start_ld(c_ct_b);
        wait_evt(1'b1, 30, lat, bc);
        check_v("pt_b", text_out, c_pt_b);
        @(negedge clk);
        start_ld(c_ct_b);
        wait_evt(1'b1, 30, lat, bc);
        check_i("done_lat_b2", lat, 11);
        check_v("pt_b_reuse", text_out, c_pt_b);

        // back-to-back under key A
        pulse_kld(c_key_a);
        wait_evt(1'b0, 30, lat, bc);
        start_ld(c_ct_a);
        wait_evt(1'b1, 30, lat, bc);
        check_v("b2b_first", text_out, c_pt_a);
        start_ld(c_ct_a);
        wait_evt(1'b1, 30, lat, bc);
        check_i("b2b_lat", lat, 11);
        check_v("b2b_second", text_out, c_pt_a);

        // key B, then ld during BUSY is dropped
        pulse_kld(c_key_b);
        wait_evt(1'b0, 30, lat, bc);
        start_ld(c_ct_b);
        repeat (3) @(negedge clk);
        start_ld(c_ct_a);
        wait_evt(1'b1, 30, lat, bc);
        check_i("busy_ld_lat", lat, 7);
        check_v("busy_ld_pt", text_out, c_pt_b);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n++;
        end
        check_i("busy_ld_extra_done", n, 0);

        // kld aborts a decrypt at cycle 5
        start_ld(c_ct_b);
        repeat (4) @(negedge clk);
        pulse_kld(c_key_a);
        wait_evt(1'b0, 30, lat, bc);
        check_i("abort_kdone_lat", lat, 11);
        check_v("abort_text_kept", text_out, c_pt_b);
        start_ld(c_ct_a);
        wait_evt(1'b1, 30, lat, bc);
        check_v("after_abort_pt", text_out, c_pt_a);

        // asynchronous reset mid-decrypt
        start_ld(c_ct_b);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_b("arst_dec_busy", busy, 1'b0);
        check_v("arst_dec_text", text_out, '0);
        @(negedge clk);
        rst = 1'b1;

        // asynchronous reset mid-expansion
        pulse_kld(c_key_b);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_b("arst_kexp_kdone", kdone, 1'b0);
        check_v("arst_kexp_text", text_out, '0);
        @(negedge clk);
        rst = 1'b1;

        start_ld(c_ct_a);
        n = 0;
        repeat (15) begin
            if (busy || done) n++;
            @(negedge clk);
        end
        check_i("post_rst_ld_ignored", n, 0);
        pulse_kld(c_key_b);
        wait_evt(1'b0, 30, lat, bc);
        start_ld(c_ct_b);
        wait_evt(1'b1, 30, lat, bc);
        check_v("post_rst_pt", text_out, c_pt_b);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
